// File: rtl/shifter_arbiter.sv
`timescale 1ns/1ps
// shifter_arbiter: shares one combinational 32-bit shifter between two
// valid/ready requesters. One operation is in flight at a time. Operands are
// registered and presented to the shifter for one cycle, and the result is
// returned on the owner's response channel.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for a request; winner's reqN_ready is asserted
// EXEC   | operands on sh_* for one cycle; sh_out captured at the end
// RESP   | result held on rsp<owner>_* until rsp<owner>_ready
module shifter_arbiter #(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,

  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_data,
  input  logic [4:0]  req0_sh,
  input  logic [2:0]  req0_ftn,

  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_data,
  input  logic [4:0]  req1_sh,
  input  logic [2:0]  req1_ftn,

  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic [31:0] rsp0_data,
  output logic        rsp0_err,

  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [31:0] rsp1_data,
  output logic        rsp1_err,

  output logic [31:0] sh_in,
  output logic [4:0]  sh_amt,
  output logic [2:0]  sh_ftn,
  input  logic [31:0] sh_out,

  output logic        busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam logic [2:0] FTN_ILLEGAL = 3'd7;

  logic [1:0]  state_q, state_d;
  logic [31:0] op_data_q, op_data_d;
  logic [4:0]  op_sh_q, op_sh_d;
  logic [2:0]  op_ftn_q, op_ftn_d;
  logic        owner_q, owner_d;
  logic        last_q, last_d;
  logic [31:0] res_q, res_d;
  logic        err_q, err_d;

  logic        any_req;
  logic        win1;
  logic [31:0] sel_data;
  logic [4:0]  sel_sh;
  logic [2:0]  sel_ftn;
  logic        in_idle;
  logic        in_exec;
  logic        in_resp;
  logic        owner_rsp_ready;

  assign in_idle = (state_q == S_IDLE);
  assign in_exec = (state_q == S_EXEC);
  assign in_resp = (state_q == S_RESP);

  // Arbitration: a lone requester wins; on a tie round-robin favours the
  // requester that was not granted last, fixed priority always favours req0.
  always_comb begin
    any_req = req0_valid | req1_valid;
    win1    = 1'b0;
    if (req0_valid && req1_valid) begin
      win1 = FIXED_PRIO ? 1'b0 : ~last_q;
    end else begin
      win1 = req1_valid;
    end
  end

  assign sel_data = win1 ? req1_data : req0_data;
  assign sel_sh   = win1 ? req1_sh   : req0_sh;
  assign sel_ftn  = win1 ? req1_ftn  : req0_ftn;

  // Ready is gated by rst_n so it is low while reset is asserted even though
  // the state register then reads IDLE.
  assign req0_ready = rst_n & in_idle & req0_valid & ~win1;
  assign req1_ready = rst_n & in_idle & req1_valid & win1;

  assign owner_rsp_ready = owner_q ? rsp1_ready : rsp0_ready;

  // Next-state and datapath register update.
  always_comb begin
    state_d   = state_q;
    op_data_d = op_data_q;
    op_sh_d   = op_sh_q;
    op_ftn_d  = op_ftn_q;
    owner_d   = owner_q;
    last_d    = last_q;
    res_d     = res_q;
    err_d     = err_q;
    case (state_q)
      S_IDLE: begin
        if (any_req) begin
          op_data_d = sel_data;
          op_sh_d   = sel_sh;
          op_ftn_d  = sel_ftn;
          owner_d   = win1;
          last_d    = win1;
          if (sel_ftn == FTN_ILLEGAL) begin
            // Illegal function never touches the shifter.
            res_d   = 32'd0;
            err_d   = 1'b1;
            state_d = S_RESP;
          end else begin
            state_d = S_EXEC;
          end
        end
      end
      S_EXEC: begin
        res_d   = sh_out;
        err_d   = 1'b0;
        state_d = S_RESP;
      end
      S_RESP: begin
        if (owner_rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and operand registers; last resets to 1 so req0 wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      op_data_q <= 32'd0;
      op_sh_q   <= 5'd0;
      op_ftn_q  <= 3'd0;
      owner_q   <= 1'b0;
      last_q    <= 1'b1;
      res_q     <= 32'd0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_data_q <= op_data_d;
      op_sh_q   <= op_sh_d;
      op_ftn_q  <= op_ftn_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      res_q     <= res_d;
      err_q     <= err_d;
    end
  end

  assign sh_in  = in_exec ? op_data_q : 32'd0;
  assign sh_amt = in_exec ? op_sh_q   : 5'd0;
  assign sh_ftn = in_exec ? op_ftn_q  : 3'd0;

  assign rsp0_valid = in_resp & ~owner_q;
  assign rsp1_valid = in_resp & owner_q;
  assign rsp0_data  = rsp0_valid ? res_q : 32'd0;
  assign rsp1_data  = rsp1_valid ? res_q : 32'd0;
  assign rsp0_err   = rsp0_valid & err_q;
  assign rsp1_err   = rsp1_valid & err_q;

  assign busy = ~in_idle;

endmodule

// File: tb/tb_shifter_arbiter.sv
`timescale 1ns/1ps
// Bench for shifter_arbiter: instance 0 is round-robin, instance 1 fixed
// priority. Each shifter is stubbed as sh_out = ~sh_in.
module tb_shifter_arbiter;

  logic        clk;
  logic        rst_n;

  logic        req_valid [2][2];
  logic        req_ready [2][2];
  logic [31:0] req_data  [2][2];
  logic [4:0]  req_sh    [2][2];
  logic [2:0]  req_ftn   [2][2];
  logic        rsp_valid [2][2];
  logic        rsp_ready [2][2];
  logic [31:0] rsp_data  [2][2];
  logic        rsp_err   [2][2];
  logic [31:0] sh_in     [2];
  logic [4:0]  sh_amt    [2];
  logic [2:0]  sh_ftn    [2];
  logic [31:0] sh_out    [2];
  logic        busy      [2];

  typedef struct {
    int          ch;
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    shifter_arbiter #(.FIXED_PRIO(g == 1)) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req0_valid (req_valid[g][0]),
      .req0_ready (req_ready[g][0]),
      .req0_data  (req_data[g][0]),
      .req0_sh    (req_sh[g][0]),
      .req0_ftn   (req_ftn[g][0]),
      .req1_valid (req_valid[g][1]),
      .req1_ready (req_ready[g][1]),
      .req1_data  (req_data[g][1]),
      .req1_sh    (req_sh[g][1]),
      .req1_ftn   (req_ftn[g][1]),
      .rsp0_valid (rsp_valid[g][0]),
      .rsp0_ready (rsp_ready[g][0]),
      .rsp0_data  (rsp_data[g][0]),
      .rsp0_err   (rsp_err[g][0]),
      .rsp1_valid (rsp_valid[g][1]),
      .rsp1_ready (rsp_ready[g][1]),
      .rsp1_data  (rsp_data[g][1]),
      .rsp1_err   (rsp_err[g][1]),
      .sh_in      (sh_in[g]),
      .sh_amt     (sh_amt[g]),
      .sh_ftn     (sh_ftn[g]),
      .sh_out     (sh_out[g]),
      .busy       (busy[g])
    );
    assign sh_out[g] = ~sh_in[g];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Result the stubbed shifter path must deliver for a request.
  function automatic logic [31:0] model_res(input logic [31:0] d, input logic [2:0] f);
    return (f == 3'd7) ? 32'd0 : ~d;
  endfunction

  task automatic push_exp(input int d, input int n);
    exp_t e;
    e.ch   = n;
    e.data = model_res(req_data[d][n], req_ftn[d][n]);
    e.err  = (req_ftn[d][n] == 3'd7);
    sb.push_back(e);
  endtask

  // Pops the scoreboard on a response handshake; idle channels must read 0.
  task automatic sb_check(input int d);
    exp_t e;
    for (int n = 0; n < 2; n++) begin
      if (rsp_valid[d][n] && rsp_ready[d][n]) begin
        check1("sb_nonempty", sb.size() != 0, 1'b1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check32("rsp_ch", 32'(n), 32'(e.ch));
          check32("rsp_data", rsp_data[d][n], e.data);
          check1("rsp_err", rsp_err[d][n], e.err);
          check1("rsp_other_valid", rsp_valid[d][1-n], 1'b0);
        end
      end else if (!rsp_valid[d][n]) begin
        check32("rsp_idle_data", rsp_data[d][n], 32'd0);
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  initial begin
    int grants;
    int last_c;
    int e;

    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      for (int n = 0; n < 2; n++) begin
        req_valid[d][n] = 1'b0;
        req_data[d][n]  = 32'd0;
        req_sh[d][n]    = 5'd0;
        req_ftn[d][n]   = 3'd0;
        rsp_ready[d][n] = 1'b0;
      end
    end

    // Reset: outputs low even with requests pending.
    req_valid[0][0] = 1'b1;
    req_valid[0][1] = 1'b1;
    #3;
    check1("rst_req0_ready", req_ready[0][0], 1'b0);
    check1("rst_req1_ready", req_ready[0][1], 1'b0);
    check1("rst_busy", busy[0], 1'b0);
    check1("rst_rsp0_valid", rsp_valid[0][0], 1'b0);
    check32("rst_sh_in", sh_in[0], 32'd0);
    req_valid[0][0] = 1'b0;
    req_valid[0][1] = 1'b0;
    #20;
    rst_n = 1'b1;

    // Single legal request on req0.
    cyc();
    req_valid[0][0] = 1'b1;
    req_data[0][0]  = 32'h35FF_FF15;
    req_sh[0][0]    = 5'd8;
    req_ftn[0][0]   = 3'd2;
    rsp_ready[0][0] = 1'b1;
    #1;
    check1("single_req0_ready", req_ready[0][0], 1'b1);
    check1("single_req1_ready", req_ready[0][1], 1'b0);
    push_exp(0, 0);
    cyc();
    req_valid[0][0] = 1'b0;
    #1;
    check1("single_exec_busy", busy[0], 1'b1);
    check32("single_sh_in", sh_in[0], 32'h35FF_FF15);
    check32("single_sh_amt", 32'(sh_amt[0]), 32'd8);
    check32("single_sh_ftn", 32'(sh_ftn[0]), 32'd2);
    check1("single_exec_rsp", rsp_valid[0][0], 1'b0);
    cyc();
    #1;
    check1("single_rsp_valid", rsp_valid[0][0], 1'b1);
    check32("single_rsp_data", rsp_data[0][0], 32'hCA00_00EA);
    check1("single_rsp_err", rsp_err[0][0], 1'b0);
    check32("single_resp_sh_in", sh_in[0], 32'd0);
    sb_check(0);
    cyc();
    #1;
    check1("single_idle_busy", busy[0], 1'b0);
    req_valid[0][0] = 1'b1;
    #1;
    check1("single_ready_again", req_ready[0][0], 1'b1);
    req_valid[0][0] = 1'b0;

    // Illegal ftn on req1: RESP one cycle after acceptance, shifter untouched.
    cyc();
    req_valid[0][1] = 1'b1;
    req_data[0][1]  = 32'hFFFF_FFFF;
    req_sh[0][1]    = 5'd3;
    req_ftn[0][1]   = 3'd7;
    rsp_ready[0][1] = 1'b1;
    #1;
    check1("ill_req1_ready", req_ready[0][1], 1'b1);
    push_exp(0, 1);
    cyc();
    req_valid[0][1] = 1'b0;
    #1;
    check32("ill_sh_in", sh_in[0], 32'd0);
    check32("ill_sh_amt", 32'(sh_amt[0]), 32'd0);
    check32("ill_sh_ftn", 32'(sh_ftn[0]), 32'd0);
    check1("ill_rsp1_valid", rsp_valid[0][1], 1'b1);
    check32("ill_rsp1_data", rsp_data[0][1], 32'd0);
    check1("ill_rsp1_err", rsp_err[0][1], 1'b1);
    sb_check(0);
    cyc();
    #1;
    check1("ill_idle_busy", busy[0], 1'b0);

    // Response backpressure on req0 for five cycles.
    cyc();
    req_valid[0][0] = 1'b1;
    req_data[0][0]  = 32'h0F0F_1234;
    req_sh[0][0]    = 5'd4;
    req_ftn[0][0]   = 3'd1;
    rsp_ready[0][0] = 1'b0;
    #1;
    check1("bp_req0_ready", req_ready[0][0], 1'b1);
    push_exp(0, 0);
    cyc();
    req_valid[0][0] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      req_valid[0][0] = 1'b1;
      req_valid[0][1] = 1'b1;
      #1;
      check1("bp_rsp_valid", rsp_valid[0][0], 1'b1);
      check32("bp_rsp_data", rsp_data[0][0], 32'hF0F0_EDCB);
      check1("bp_busy", busy[0], 1'b1);
      check1("bp_req0_ready_low", req_ready[0][0], 1'b0);
      check1("bp_req1_ready_low", req_ready[0][1], 1'b0);
      check32("bp_sh_in", sh_in[0], 32'd0);
      sb_check(0);
      req_valid[0][0] = 1'b0;
      req_valid[0][1] = 1'b0;
    end
    cyc();
    rsp_ready[0][0] = 1'b1;
    #1;
    sb_check(0);
    cyc();
    #1;
    check1("bp_idle_after", busy[0], 1'b0);

    // Reset during EXEC drops the operation.
    cyc();
    req_valid[0][0] = 1'b1;
    req_data[0][0]  = 32'h1234_5678;
    req_sh[0][0]    = 5'd1;
    req_ftn[0][0]   = 3'd0;
    #1;
    check1("rmid_req0_ready", req_ready[0][0], 1'b1);
    cyc();
    req_valid[0][0] = 1'b0;
    #1;
    check1("rmid_exec_busy", busy[0], 1'b1);
    check32("rmid_exec_sh_in", sh_in[0], 32'h1234_5678);
    rst_n = 1'b0;
    #1;
    check1("rmid_async_busy", busy[0], 1'b0);
    check32("rmid_async_sh_in", sh_in[0], 32'd0);
    check32("rmid_async_sh_amt", 32'(sh_amt[0]), 32'd0);
    check1("rmid_async_rsp", rsp_valid[0][0], 1'b0);
    cyc();
    #1;
    check1("rmid_held_busy", busy[0], 1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      #1;
      check1("rmid_no_rsp", rsp_valid[0][0], 1'b0);
      check1("rmid_idle", busy[0], 1'b0);
      sb_check(0);
    end

    // Round-robin: both valid, first tie after reset goes to req0.
    rsp_ready[0][0] = 1'b1;
    rsp_ready[0][1] = 1'b1;
    grants = 0;
    last_c = 0;
    for (int c = 0; c < 40; c++) begin
      if (grants == 4 && sb.size() == 0) break;
      cyc();
      req_valid[0][0] = (grants < 4);
      req_valid[0][1] = (grants < 4);
      req_data[0][0]  = 32'hA5A5_0000 + 32'(grants);
      req_data[0][1]  = 32'h5A5A_0000 ^ (32'(grants) << 8);
      req_ftn[0][0]   = 3'(grants % 7);
      req_ftn[0][1]   = 3'((grants + 3) % 7);
      req_sh[0][0]    = 5'(grants * 5);
      req_sh[0][1]    = 5'(grants * 5 + 1);
      #1;
      sb_check(0);
      if (req_ready[0][0] || req_ready[0][1]) begin
        e = grants % 2;
        check1("rr_grant", req_ready[0][e], 1'b1);
        check1("rr_other", req_ready[0][1-e], 1'b0);
        if (grants > 0) check32("rr_interval", 32'(c - last_c), 32'd3);
        push_exp(0, e);
        last_c = c;
        grants++;
      end
    end
    check1("rr_done", (grants == 4) && (sb.size() == 0), 1'b1);
    req_valid[0][0] = 1'b0;
    req_valid[0][1] = 1'b0;

    // Fixed priority: req0 takes every grant while it stays valid.
    rsp_ready[1][0] = 1'b1;
    rsp_ready[1][1] = 1'b1;
    req_data[1][1]  = 32'h0000_BEEF;
    req_ftn[1][1]   = 3'd4;
    grants = 0;
    for (int c = 0; c < 40; c++) begin
      if (grants == 3 && sb.size() == 0) break;
      cyc();
      req_valid[1][0] = (grants < 3);
      req_valid[1][1] = (grants < 3);
      req_data[1][0]  = 32'hC0DE_0000 | 32'(grants * 17);
      req_ftn[1][0]   = 3'(grants + 1);
      req_sh[1][0]    = 5'(grants + 2);
      #1;
      sb_check(1);
      if (req_valid[1][0]) check1("fp_req1_ready", req_ready[1][1], 1'b0);
      if (req_ready[1][0]) begin
        push_exp(1, 0);
        grants++;
      end
    end
    check1("fp_done", (grants == 3) && (sb.size() == 0), 1'b1);
    req_valid[1][0] = 1'b0;
    req_valid[1][1] = 1'b0;

    check1("sb_drained", sb.size() == 0, 1'b1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
